// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: CPU/DMA arbiter and req/ack sequencer for the shared data RAM,
// with byte-lane steering and load extension. Optional ACC watchdog: DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
    parameter int size           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req_i,
    input  logic            cpu_we_i,
    input  logic [size-1:0] cpu_addr_i,
    input  logic [size-1:0] cpu_wdata_i,
    input  logic [2:0]      cpu_ctrl_i,
    output logic [size-1:0] cpu_rdata_o,
    output logic            cpu_stall_o,
    input  logic            dma_req_i,
    input  logic            dma_we_i,
    input  logic [size-1:0] dma_addr_i,
    input  logic [size-1:0] dma_wdata_i,
    input  logic [2:0]      dma_ctrl_i,
    output logic [size-1:0] dma_rdata_o,
    output logic            dma_done_o,
    output logic            ram_req_o,
    output logic            ram_we_o,
    output logic [size-1:0] ram_addr_o,
    output logic [size-1:0] ram_wdata_o,
    output logic [3:0]      ram_be_o,
    input  logic            ram_ack_i,
    input  logic [size-1:0] ram_rdata_i,
    output logic            err_o
);

    typedef enum logic [2:0] {IDLE, ACC_CPU, ACC_DMA, DONE_CPU, DONE_DMA} state_t;

    state_t          state;
    logic            last_dma;
    logic [2:0]      acc_ctrl;
    logic [1:0]      acc_off;

    logic            gnt_cpu;
    logic            gnt_dma;
    logic            sel_we;
    logic [size-1:0] sel_addr;
    logic [size-1:0] sel_wdata;
    logic [2:0]      sel_ctrl;
    logic [size-1:0] ld_data;

    function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] off);
        case (ctrl)
            3'b000, 3'b100: lane_be = 4'b0001 << off;
            3'b001, 3'b101: lane_be = off[1] ? 4'b1100 : 4'b0011;
            default:        lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [size-1:0] lane_wdata(input logic [2:0] ctrl,
                                                   input logic [size-1:0] wdata);
        case (ctrl)
            3'b000, 3'b100: lane_wdata = {(size/8){wdata[7:0]}};
            3'b001, 3'b101: lane_wdata = {(size/16){wdata[15:0]}};
            default:        lane_wdata = wdata;
        endcase
    endfunction

    function automatic logic [size-1:0] load_extend(input logic [2:0] ctrl,
                                                    input logic [1:0] off,
                                                    input logic [size-1:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (ctrl)
            3'b000:  load_extend = {{(size-8){b[7]}}, b};
            3'b100:  load_extend = {{(size-8){1'b0}}, b};
            3'b001:  load_extend = {{(size-16){h[15]}}, h};
            3'b101:  load_extend = {{(size-16){1'b0}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // Round-robin: on a tie the port that did not own the last access wins.
    assign gnt_cpu   = cpu_req_i & (~dma_req_i | last_dma);
    assign gnt_dma   = dma_req_i & ~gnt_cpu;
    assign sel_we    = gnt_cpu ? cpu_we_i    : dma_we_i;
    assign sel_addr  = gnt_cpu ? cpu_addr_i  : dma_addr_i;
    assign sel_wdata = gnt_cpu ? cpu_wdata_i : dma_wdata_i;
    assign sel_ctrl  = gnt_cpu ? cpu_ctrl_i  : dma_ctrl_i;

    assign ld_data     = ram_we_o ? '0 : load_extend(acc_ctrl, acc_off, ram_rdata_i);
    assign cpu_stall_o = cpu_req_i & (state != DONE_CPU);

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_dma    <= 1'b1;
            acc_ctrl    <= 3'b000;
            acc_off     <= 2'b00;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_be_o    <= 4'b0000;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            cpu_rdata_o <= '0;
            dma_rdata_o <= '0;
            dma_done_o  <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt     <= '0;
            err_o       <= 1'b0;
`endif
        end else begin
            dma_done_o <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            err_o      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (gnt_cpu || gnt_dma) begin
                        state       <= gnt_cpu ? ACC_CPU : ACC_DMA;
                        ram_req_o   <= 1'b1;
                        ram_we_o    <= sel_we;
                        ram_addr_o  <= {sel_addr[size-1:2], 2'b00};
                        ram_be_o    <= sel_we ? lane_be(sel_ctrl, sel_addr[1:0]) : 4'b0000;
                        ram_wdata_o <= lane_wdata(sel_ctrl, sel_wdata);
                        acc_ctrl    <= sel_ctrl;
                        acc_off     <= sel_addr[1:0];
`ifdef DMEM_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                ACC_CPU, ACC_DMA: begin
                    if (ram_ack_i) begin
                        ram_req_o <= 1'b0;
                        if (state == ACC_CPU) begin
                            cpu_rdata_o <= ld_data;
                            last_dma    <= 1'b0;
                            state       <= DONE_CPU;
                        end else begin
                            dma_rdata_o <= ld_data;
                            dma_done_o  <= 1'b1;
                            last_dma    <= 1'b1;
                            state       <= DONE_DMA;
                        end
                    end
`ifdef DMEM_TIMEOUT_EN
                    // Give up on a silent RAM; the requester still sees a completion.
                    else if (tmo_hit) begin
                        ram_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        if (state == ACC_CPU) begin
                            cpu_rdata_o <= '0;
                            state       <= DONE_CPU;
                        end else begin
                            dma_rdata_o <= '0;
                            dma_done_o  <= 1'b1;
                            state       <= DONE_DMA;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                DONE_CPU, DONE_DMA: state <= IDLE;
                default:            state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-level reference model checked every cycle,
// plus directed accesses with hand-computed results.
module tb_dmem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic [2:0]  cpu_ctrl_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o;
    logic        dma_req_i, dma_we_i;
    logic [31:0] dma_addr_i, dma_wdata_i;
    logic [2:0]  dma_ctrl_i;
    logic [31:0] dma_rdata_o;
    logic        dma_done_o;
    logic        ram_req_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic        ram_ack_i;
    logic [31:0] ram_rdata_i;
    logic        err_o;

    logic        resp_en = 1'b1;
    logic        ack_auto = 1'b0;
    logic        ack_man = 1'b0;
    int          ack_lat = 0;
    int          rcnt = 0;
    logic [31:0] rd_word = 32'h0;

    assign ram_ack_i   = resp_en ? ack_auto : ack_man;
    assign ram_rdata_i = rd_word;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.size(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_ctrl_i(cpu_ctrl_i), .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_ctrl_i(dma_ctrl_i), .dma_rdata_o(dma_rdata_o),
        .dma_done_o(dma_done_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_ack_i(ram_ack_i),
        .ram_rdata_i(ram_rdata_i), .err_o(err_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_wait(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no completion within cycle bound (t=%0t)", name, $time);
    endtask

    // Reference rules written from the access size, not from lane tables.
    function automatic int nbytes(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic we, input logic [2:0] c, input logic [31:0] a);
        int n;
        int off;
        n   = nbytes(c);
        off = (int'(a % 4) / n) * n;
        if (!we) return 4'b0000;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] c, input logic [31:0] wd);
        case (nbytes(c))
            1:       return (wd & 32'hFF) * 32'h01010101;
            2:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] word);
        int     n;
        int     off;
        longint v;
        n   = nbytes(c);
        off = (int'(a % 4) / n) * n;
        if (n == 4) return word;
        v = longint'(word >> (8 * off)) & ((64'sd1 <<< (8 * n)) - 1);
        if ((c == 3'b000 || c == 3'b001) && v >= (64'sd1 <<< (8 * n - 1)))
            v = v - (64'sd1 <<< (8 * n));
        return v[31:0];
    endfunction

    // RAM responder: ack after ack_lat waiting cycles of a raised request.
    always @(posedge clk) begin
        #2;
        if (resp_en && ram_req_o && !ack_auto) begin
            if (rcnt == ack_lat) ack_auto = 1'b1;
            else rcnt++;
        end else begin
            ack_auto = 1'b0;
            rcnt     = 0;
        end
    end

    // Transaction model: one access at a time, a grant only from rest, a completion cycle after.
    bit          m_valid = 0;
    bit          m_busy = 0;
    bit          m_fin = 0;
    int          m_own = 0;
    int          m_fin_own = 0;
    int          m_acc_n = 0;
    bit          m_last_dma = 1;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_ctrl;
    logic        e_req = 0, e_done = 0, e_err = 0;
    logic [31:0] e_cpu_rd = 0, e_dma_rd = 0;

    task automatic model_finish(input logic [31:0] v);
        e_req     = 1'b0;
        m_busy    = 0;
        m_fin     = 1;
        m_fin_own = m_own;
        if (m_own == 1) e_cpu_rd = v;
        else begin
            e_dma_rd = v;
            e_done   = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        m_valid = 1;
        if (reset) begin
            m_busy = 0; m_fin = 0; m_fin_own = 0; m_last_dma = 1;
            e_req = 0; e_done = 0; e_err = 0; e_cpu_rd = 0; e_dma_rd = 0;
        end else begin
            e_done = 0;
            e_err  = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (m_busy) begin
                m_acc_n++;
                if (ram_ack_i) begin
                    m_last_dma = (m_own == 2);
                    model_finish(m_we ? 32'h0 : ref_load(m_ctrl, m_addr, ram_rdata_i));
                end
`ifdef DMEM_TIMEOUT_EN
                else if (m_acc_n == TMO) begin
                    model_finish(32'h0);
                    e_err = 1'b1;
                end
`endif
            end else if (cpu_req_i || dma_req_i) begin
                if (dma_req_i && (!cpu_req_i || !m_last_dma)) begin
                    m_own = 2; m_we = dma_we_i; m_addr = dma_addr_i;
                    m_wdata = dma_wdata_i; m_ctrl = dma_ctrl_i;
                end else begin
                    m_own = 1; m_we = cpu_we_i; m_addr = cpu_addr_i;
                    m_wdata = cpu_wdata_i; m_ctrl = cpu_ctrl_i;
                end
                m_busy  = 1;
                m_acc_n = 0;
                e_req   = 1'b1;
            end
        end
    end

    int          n_done = 0;
    int          n_err = 0;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ram_req", 32'(ram_req_o), 32'(e_req));
            chk("cpu_stall", 32'(cpu_stall_o), 32'(cpu_req_i && !(m_fin && m_fin_own == 1)));
            chk("dma_done", 32'(dma_done_o), 32'(e_done));
            chk("err", 32'(err_o), 32'(e_err));
            if (e_req) begin
                chk("ram_we", 32'(ram_we_o), 32'(m_we));
                chk("ram_addr", ram_addr_o, m_addr & 32'hFFFF_FFFC);
                chk("ram_be", 32'(ram_be_o), 32'(ref_be(m_we, m_ctrl, m_addr)));
                if (m_we) chk("ram_wdata", ram_wdata_o, ref_wdata(m_ctrl, m_wdata));
            end
            if (m_fin && m_fin_own == 1) chk("cpu_rdata", cpu_rdata_o, e_cpu_rd);
            if (e_done) chk("dma_rdata", dma_rdata_o, e_dma_rd);
        end
        if (ram_req_o === 1'b1) begin
            s_be = ram_be_o; s_addr = ram_addr_o; s_wdata = ram_wdata_o; s_we = ram_we_o;
        end
        if (dma_done_o === 1'b1) n_done++;
        if (err_o === 1'b1) n_err++;
    end

    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] ctrl, output logic [31:0] rd,
                              output int stalls, output time t);
        bit got;
        @(posedge clk); #2;
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_ctrl_i = ctrl;
        got = 0; stalls = 0; rd = 32'h0; t = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (cpu_stall_o) stalls++;
            else begin
                rd = cpu_rdata_o; t = $time; got = 1;
            end
        end
        if (!got) fail_wait("cpu_wait");
        @(posedge clk); #2;
        cpu_req_i = 1'b0;
    endtask

    task automatic dma_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] ctrl, output logic [31:0] rd, output time t);
        bit got;
        @(posedge clk); #2;
        dma_req_i = 1'b1; dma_we_i = we; dma_addr_i = addr; dma_wdata_i = wdata; dma_ctrl_i = ctrl;
        got = 0; rd = 32'h0; t = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (dma_done_o) begin
                rd = dma_rdata_o; t = $time; got = 1;
            end
        end
        if (!got) fail_wait("dma_wait");
        @(posedge clk); #2;
        dma_req_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, rd2;
        int          st;
        time         t1, t2;
        int          d0;

        reset = 1'b1;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0; cpu_ctrl_i = 0;
        dma_req_i = 0; dma_we_i = 0; dma_addr_i = 0; dma_wdata_i = 0; dma_ctrl_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_req", 32'(ram_req_o), 32'h0);
        chk("rst_ram_we", 32'(ram_we_o), 32'h0);
        chk("rst_ram_be", 32'(ram_be_o), 32'h0);
        chk("rst_ram_addr", ram_addr_o, 32'h0);
        chk("rst_ram_wdata", ram_wdata_o, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata_o, 32'h0);
        chk("rst_dma_rdata", dma_rdata_o, 32'h0);
        chk("rst_dma_done", 32'(dma_done_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        // LW with ack in the first ACC cycle.
        rd_word = 32'hDEADBEEF; ack_lat = 0;
        cpu_access(1'b0, 32'h100, 32'h0, 3'b010, rd, st, t1);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_stalls", 32'(st), 32'd2);
        chk("lw_be", 32'(s_be), 32'h0);
        chk("lw_addr", s_addr, 32'h100);

        rd_word = 32'h80123456;
        cpu_access(1'b0, 32'h103, 32'h0, 3'b000, rd, st, t1);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        cpu_access(1'b0, 32'h103, 32'h0, 3'b100, rd, st, t1);
        chk("lbu_rdata", rd, 32'h00000080);

        cpu_access(1'b1, 32'h102, 32'h1234, 3'b001, rd, st, t1);
        chk("sh_be", 32'(s_be), 32'hC);
        chk("sh_wdata", s_wdata, 32'h12341234);
        chk("sh_we", 32'(s_we), 32'h1);
        chk("sh_addr", s_addr, 32'h100);
        chk("sh_rdata", rd, 32'h0);

        rd_word = 32'hBEEF1234; ack_lat = 2;
        cpu_access(1'b0, 32'h102, 32'h0, 3'b001, rd, st, t1);
        chk("lh_rdata", rd, 32'hFFFFBEEF);
        chk("lh_stalls", 32'(st), 32'd4);
        cpu_access(1'b0, 32'h103, 32'h0, 3'b101, rd, st, t1);
        chk("lhu_odd_rdata", rd, 32'h0000BEEF);
        cpu_access(1'b0, 32'h101, 32'h0, 3'b001, rd, st, t1);
        chk("lh_low_rdata", rd, 32'h00001234);

        ack_lat = 1;
        cpu_access(1'b1, 32'h101, 32'h77AB, 3'b000, rd, st, t1);
        chk("sb_be", 32'(s_be), 32'h2);
        chk("sb_wdata", s_wdata, 32'hABABABAB);
        cpu_access(1'b1, 32'h101, 32'h01020304, 3'b110, rd, st, t1);
        chk("rsv_be", 32'(s_be), 32'hF);
        chk("rsv_wdata", s_wdata, 32'h01020304);
        chk("rsv_addr", s_addr, 32'h100);

        // Stray acks with nothing in flight change nothing.
        resp_en = 1'b0; rd_word = 32'hFFFFFFFF;
        @(posedge clk); #2; ack_man = 1'b1;
        @(posedge clk); #2; ack_man = 1'b0;
        @(negedge clk);
        chk("stray_ack_req", 32'(ram_req_o), 32'h0);
        chk("stray_ack_done", 32'(dma_done_o), 32'h0);
        resp_en = 1'b1;

        rd_word = 32'h11223344; ack_lat = 2;
        dma_access(1'b0, 32'h200, 32'h0, 3'b010, rd, t2);
        chk("dma_lw_rdata", rd, 32'h11223344);

        // Simultaneous requests, twice: CPU first each time.
        rd_word = 32'hCAFEF00D; ack_lat = 0;
        d0 = n_done;
        fork
            cpu_access(1'b0, 32'h104, 32'h0, 3'b010, rd, st, t1);
            dma_access(1'b0, 32'h206, 32'h0, 3'b101, rd2, t2);
        join
        chk("rr1_order", 32'(t1 < t2), 32'h1);
        chk("rr1_cpu_rdata", rd, 32'hCAFEF00D);
        chk("rr1_dma_rdata", rd2, 32'h0000CAFE);
        chk("rr1_dma_pulses", 32'(n_done - d0), 32'd1);
        d0 = n_done;
        fork
            cpu_access(1'b0, 32'h100, 32'h0, 3'b000, rd, st, t1);
            dma_access(1'b1, 32'h203, 32'h5A, 3'b000, rd2, t2);
        join
        chk("rr2_order", 32'(t1 < t2), 32'h1);
        chk("rr2_cpu_rdata", rd, 32'h0000000D);
        chk("rr2_dma_rdata", rd2, 32'h0);
        chk("rr2_dma_pulses", 32'(n_done - d0), 32'd1);

        // CPU arrives while a DMA access is in flight.
        ack_lat = 3; rd_word = 32'h00FF7F01;
        fork
            dma_access(1'b0, 32'h300, 32'h0, 3'b010, rd2, t2);
            begin
                repeat (2) @(posedge clk);
                cpu_access(1'b0, 32'h101, 32'h0, 3'b000, rd, st, t1);
            end
        join
        chk("late_cpu_order", 32'(t2 < t1), 32'h1);
        chk("late_cpu_rdata", rd, 32'h0000007F);
        chk("late_dma_rdata", rd2, 32'h00FF7F01);

        // Reset in the middle of an ACC, ack two cycles later.
        resp_en = 1'b0; rd_word = 32'h12345678;
        @(posedge clk); #2;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h108; cpu_ctrl_i = 3'b010;
        @(posedge clk);
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0; cpu_req_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", 32'(ram_req_o), 32'h0);
        @(posedge clk); #2; ack_man = 1'b1;
        @(posedge clk); #2; ack_man = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(ram_req_o), 32'h0);
        chk("late_ack_rdata", cpu_rdata_o, 32'h0);
        chk("late_ack_stall", 32'(cpu_stall_o), 32'h0);
        resp_en = 1'b1; ack_lat = 0;

        cpu_access(1'b0, 32'h108, 32'h0, 3'b010, rd, st, t1);
        chk("post_rst_rdata", rd, 32'h12345678);

`ifdef DMEM_TIMEOUT_EN
        ack_lat = 1000;
        d0 = n_err;
        cpu_access(1'b0, 32'h10C, 32'h0, 3'b010, rd, st, t1);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_stalls", 32'(st), 32'd5);
        chk("tmo_err_pulses", 32'(n_err - d0), 32'd1);
        ack_lat = 0;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
